// File: rtl/my_uart_top.sv
// 8N1 UART echo: 2-FF synchronised receiver, one-byte holding register, transmitter.
// Optional UART_STOP_CHECK_EN: drop bytes whose stop bit samples low and wait for line high.
module my_uart_top #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rs232_rx,
  output logic rs232_tx
);

  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BPS_CNT / 2;
  localparam int CW      = $clog2(BPS_CNT);
  localparam logic [CW-1:0] BIT_END  = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic            rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_done;
  logic [7:0]      rx_byte;
  logic [7:0]      hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  tx_state_t       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  assign rx_byte  = rx_shift_q;
  assign rs232_tx = tx_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
`ifdef UART_STOP_CHECK_EN
          if (rx_s_q) begin
            rx_done    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_BRK;
          end
`else
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
`endif
        end
      end
      RX_BRK: begin
        // Framing error: a held-low line must not be mistaken for a new start bit.
        rx_cnt_d = '0;
        if (rx_s_q) rx_state_d = RX_IDLE;
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q + 1'b1;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_d         = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (hold_valid_q) begin
          tx_shift_d   = hold_q;
          hold_valid_d = 1'b0;
          tx_d         = 1'b0;
          tx_state_d   = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_d       = tx_shift_q[1];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
    // A fresh byte wins over the transmitter's clear; an unsent older byte is overwritten.
    if (rx_done) begin
      hold_d       = rx_byte;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_q         <= 1'b1;
    end else begin
      rx_meta_q    <= rs232_rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
    end
  end

endmodule

// File: tb/tb_my_uart_top.sv
// Directed bench for my_uart_top at a scaled-down rate (8 clocks per bit) so every scenario fits a short run.
module tb_my_uart_top;

  localparam int BPS  = 8;
  localparam int HALF = 4;
  // Input edge -> 2 sync flops -> half bit + 9 bits to stop sample -> hold write + tx load.
  localparam int LAT  = 2 + HALF + 9 * BPS + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rs232_rx = 1'b1;
  logic rs232_tx;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int tx_edges = 0;

  typedef struct {
    logic [7:0] b;
    int         st;
    logic       ok;
  } frame_t;
  frame_t mon_q[$];

  logic [7:0] m_b;
  int         m_st;
  logic       m_ok;

  my_uart_top #(.CLK_FREQ(800_000), .BAUD(100_000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs232_rx (rs232_rx),
    .rs232_tx (rs232_tx)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(rs232_tx) tx_edges++;

  // Line monitor: decodes every frame on rs232_tx by mid-bit sampling.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rs232_tx === 1'b0) begin
        m_st = cyc;
        m_ok = 1'b1;
        repeat (HALF) @(posedge clk); #1;
        if (rs232_tx !== 1'b0) m_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (BPS) @(posedge clk); #1;
          m_b[i] = rs232_tx;
        end
        repeat (BPS) @(posedge clk); #1;
        if (rs232_tx !== 1'b1) m_ok = 1'b0;
        mon_q.push_back('{b: m_b, st: m_st, ok: m_ok});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; rst_bit >= 0 pulses rst_n low for one cycle inside that data bit.
  task automatic send(input logic [7:0] b, input logic stop_val, input int rst_bit, output int e);
    rs232_rx = 1'b0;
    e = cyc;
    wait_cyc(BPS);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      if (i == rst_bit) begin
        wait_cyc(2);
        rst_n = 1'b0;
        wait_cyc(1);
        check("tx_during_midframe_reset", rs232_tx, 1);
        rst_n = 1'b1;
        wait_cyc(BPS - 3);
      end else begin
        wait_cyc(BPS);
      end
    end
    rs232_rx = stop_val;
    wait_cyc(BPS);
  endtask

  task automatic expect_echo(input string tag, input logic [7:0] b, input int e, input bit chk_lat);
    frame_t f;
    bit got = 1'b0;
    for (int i = 0; i < 40 * BPS && mon_q.size() == 0; i++) wait_cyc(1);
    if (mon_q.size() != 0) begin
      got = 1'b1;
      f = mon_q.pop_front();
    end
    check({tag, "_received"}, got, 1);
    if (got) begin
      check({tag, "_byte"}, f.b, b);
      check({tag, "_framing"}, f.ok, 1);
      if (chk_lat) check({tag, "_start_cycle"}, f.st, e + LAT);
    end
  endtask

  task automatic expect_none(input string tag, input int n);
    int edges0;
    edges0 = tx_edges;
    wait_cyc(n);
    check({tag, "_no_frame"}, mon_q.size(), 0);
    check({tag, "_no_tx_edges"}, tx_edges - edges0, 0);
    check({tag, "_tx_idle"}, rs232_tx, 1);
  endtask

  initial begin
    int e, e1;
    logic [7:0] b;

    // Reset for one cycle, line idle.
    @(posedge clk); #1;
    check("tx_in_reset", rs232_tx, 1);
    rst_n = 1'b1;
    expect_none("after_reset", 10 * BPS);

    // Single echoes with exact start-bit timing.
    send(8'h55, 1'b1, -1, e);
    expect_echo("echo_55", 8'h55, e, 1'b1);
    send(8'hA7, 1'b1, -1, e);
    expect_echo("echo_a7", 8'hA7, e, 1'b1);

    // Glitch shorter than half a bit.
    rs232_rx = 1'b0;
    wait_cyc(2);
    rs232_rx = 1'b1;
    expect_none("glitch", 20 * BPS);

    // Back-to-back frames with no idle between stop and start.
    send(8'h00, 1'b1, -1, e1);
    send(8'hFF, 1'b1, -1, e);
    send(8'h3C, 1'b1, -1, e);
    expect_echo("b2b_00", 8'h00, e1, 1'b1);
    expect_echo("b2b_ff", 8'hFF, 0, 1'b0);
    expect_echo("b2b_3c", 8'h3C, 0, 1'b0);

    // Stop bit sampled low.
    send(8'h81, 1'b0, -1, e);
    rs232_rx = 1'b1;
`ifdef UART_STOP_CHECK_EN
    expect_none("stop_err_81", 20 * BPS);
`else
    expect_echo("stop_low_81", 8'h81, e, 1'b1);
`endif
    wait_cyc(2 * BPS);
    send(8'h42, 1'b1, -1, e);
    expect_echo("after_stop_err_42", 8'h42, e, 1'b1);

    // Reset in data bit 5 of 0xF0 (line high from there on) drops the frame.
    send(8'hF0, 1'b1, 5, e);
    expect_none("midframe_reset", 20 * BPS);
    send(8'h99, 1'b1, -1, e);
    expect_echo("after_reset_99", 8'h99, e, 1'b1);

    // Every byte value, then random bytes.
    for (int v = 0; v < 256; v++) begin
      b = 8'(v);
      send(b, 1'b1, -1, e);
      expect_echo("all", b, e, 1'b1);
    end
    for (int k = 0; k < 50; k++) begin
      b = 8'($urandom_range(0, 255));
      send(b, 1'b1, -1, e);
      expect_echo("rand", b, e, 1'b1);
    end
    expect_none("final", 12 * BPS);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/my_uart_top.md
# my_uart_top

Single-channel 8N1 UART echo block for the 50 MHz board domain. It receives serial bytes on `rs232_rx` and retransmits each correctly framed byte unchanged on `rs232_tx`. It sits at the top of the serial path and contains a receiver, a one-byte holding register and a transmitter that share one baud-rate timebase definition.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s. The bit period is `BPS_CNT = CLK_FREQ/BAUD` cycles (integer division, 5208). The half bit is `BPS_CNT/2` (2604).

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rs232_rx`  in  1  serial input; idle high; asynchronous to `clk`.
- `rs232_tx`  out  1  serial output; idle high; registered.

## Operation
- **Input synchronisation:** `rs232_rx` passes through a 2-FF synchroniser into `rx_s`. Start detection uses the falling edge of `rx_s` (previous value 1, current value 0).
- **Receiver states:** IDLE → START → DATA → STOP → IDLE. Each state has its own counter of `BPS_CNT` cycles.
  - IDLE: waits for a falling edge, then enters START and clears the counter.
  - START: after `BPS_CNT/2` cycles, samples `rx_s`.
    - 1: the event is a glitch; return to IDLE.
    - 0: go to DATA.
  - DATA: samples 8 bits, one every `BPS_CNT` cycles, LSB first, into a shift register.
  - STOP: samples `rx_s` `BPS_CNT` cycles after bit 7. It then asserts `rx_done` for one cycle with `rx_byte` and returns to IDLE.
  - In IDLE, a new falling edge is accepted from the cycle after the stop sample onward.
- **Holding register:** `rx_done` writes `rx_byte` into a one-byte holding register and sets `hold_valid`. If `hold_valid` is already set, the new byte overwrites the old one and the old byte is lost.
- **Transmitter states:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: when `hold_valid` is set, it copies the byte into `tx_shift`, clears `hold_valid` and drives the start bit 0.
  - DATA: drives 8 data bits LSB first.
  - STOP: drives the stop bit 1.
  - Each bit lasts exactly `BPS_CNT` cycles. The transmitter returns to IDLE after the stop bit.
- Receiver and transmitter run independently. A byte can be received while the previous byte is still being transmitted.
- **Reset:** asserting `rst_n` low clears all state at any time, including mid-frame.
  - `rs232_tx` = 1.
  - Both state machines go to IDLE.
  - Counters = 0.
  - `hold_valid` = 0.
  - The synchroniser flops = 1.
  - A frame that was in progress is dropped without any output.

## Timing
- Let cycle 0 be the first cycle in which the synchroniser output shows the falling edge of the start bit.
  - Start-bit check: cycle 2604.
  - Data bit i (i = 0..7): sampled at cycle 2604 + (i+1)·5208.
  - Stop bit: sampled at cycle 2604 + 9·5208 = 49476.
- **Echo latency:** `rs232_tx` falls for the start bit 2 cycles after the stop sample (hold write, then transmitter load). This applies when the transmitter is idle.
- The transmitted frame is 10 × 5208 = 52080 cycles long.
- **Sampling tolerance:** the receiver tolerates ±4 % baud mismatch, because sampling is at mid-bit.
- **Back-to-back input:** with continuous input frames at the same baud, the transmitter finishes each frame 2 cycles after the next byte is written to the holding register. That byte then starts immediately, so no byte is lost.

## Configuration
- `UART_STOP_CHECK_EN`
  - Defined: a stop-bit sample of 0 is a framing error. The byte is discarded, `rx_done` is not asserted, and the receiver returns to IDLE only after `rx_s` has been seen high.
  - Undefined: the stop-bit value is ignored and every byte is echoed.

## Test plan
- **Reset:** hold `rst_n` = 0 for 1 cycle with `rs232_rx` = 1 → `rs232_tx` = 1 throughout, and no edges for 10 bit times after release.
- **Single echo:** send 0x55, then 0xA7, at 104167 ns per bit → `rs232_tx` carries 0x55, then 0xA7, LSB first. Each start bit appears 2 cycles after the corresponding stop-bit sample.
- **Exhaustive:** send all bytes 0x00..0xFF, one every 16 bit times, plus 50 random bytes → every echoed byte equals the sent byte; mismatch count = 0.
- **Glitch rejection:** drive `rs232_rx` low for 1000 cycles (less than half a bit) → no frame is received and `rs232_tx` stays 1.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle between stop and start bits → the three bytes are echoed in order with no loss.
- **Framing and reset:**
  - With `UART_STOP_CHECK_EN` defined, send 0x81 with stop bit = 0 → no echo. A following valid 0x42 → 0x42 is echoed.
  - Pulse `rst_n` low mid-frame → that frame produces no output.
